// File: rtl/zx81_tape_player.sv
// Plays a .p/.o tape image from the tape buffer RAM as ZX81 cassette pulses.
// The output feeds the ULA tape input, so the stock ROM LOAD routine can read it.
module zx81_tape_player #(
    parameter int         CLK_HZ    = 52000000,
    parameter int         PULSE_US  = 150,
    parameter int         GAP_US    = 1300,
    parameter int         LEADER_US = 500000,
    parameter int         NAME_EN   = 1,
    parameter logic [7:0] NAME_BYTE = 8'hA6,
    parameter int         POLARITY  = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] tape_size,
    output logic [13:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done,
    output logic [13:0] progress
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LEADER, S_LOADN, S_FETCH, S_BITSTART, S_PHI, S_PLO, S_GAP, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [PW-1:0] presc;
    logic [19:0] dur, dur_max;
    logic [3:0]  pulse_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        fetch_wait;
    logic        name_phase;
    logic        tick, timer_done, last_byte;

    assign tick      = (presc == PW'(DIV - 1));
    assign last_byte = ({1'b0, rd_addr} + 15'd1) >= {1'b0, tape_size};

    always_comb begin
        dur_max = 20'd0;
        case (state)
            S_LEADER:     dur_max = 20'(LEADER_US - 1);
            S_PHI, S_PLO: dur_max = 20'(PULSE_US - 1);
            S_GAP:        dur_max = 20'(GAP_US - 1);
            default:      dur_max = 20'd0;
        endcase
    end

    assign timer_done = tick && (dur == dur_max);

    // Between bits GAP goes straight to PHI; BITSTART only costs a clock once per byte.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start && tape_size != 14'd0) state_nxt = S_LEADER;
            S_LEADER:   if (timer_done) state_nxt = (NAME_EN != 0) ? S_LOADN : S_FETCH;
            S_LOADN:    state_nxt = S_BITSTART;
            S_FETCH:    if (fetch_wait) state_nxt = S_BITSTART;
            S_BITSTART: state_nxt = S_PHI;
            S_PHI:      if (timer_done) state_nxt = S_PLO;
            S_PLO:      if (timer_done) state_nxt = (pulse_cnt > 4'd1) ? S_PHI : S_GAP;
            S_GAP: begin
                if (timer_done) begin
                    if (bit_cnt != 3'd7)              state_nxt = S_PHI;
                    else if (name_phase || !last_byte) state_nxt = S_FETCH;
                    else                              state_nxt = S_DONE;
                end
            end
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (stop) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            presc      <= '0;
            dur        <= 20'd0;
            pulse_cnt  <= 4'd0;
            bit_cnt    <= 3'd0;
            rd_addr    <= 14'd0;
            progress   <= 14'd0;
            fetch_wait <= 1'b0;
            name_phase <= 1'b0;
        end else begin
            state <= state_nxt;
            // Timer restarts on every state change so each timed state is exactly N ticks.
            if (state_nxt != state) begin
                presc <= '0;
                dur   <= 20'd0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) dur <= dur + 20'd1;
            end

            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LEADER) begin
                        rd_addr    <= 14'd0;
                        progress   <= 14'd0;
                        bit_cnt    <= 3'd0;
                        fetch_wait <= 1'b0;
                        name_phase <= (NAME_EN != 0);
                    end
                end
                S_LOADN: shreg <= NAME_BYTE;
                S_FETCH: begin
                    fetch_wait <= ~fetch_wait;
                    if (fetch_wait) begin
                        shreg    <= rd_data;
                        progress <= rd_addr;
                    end
                end
                S_BITSTART: pulse_cnt <= shreg[7] ? 4'd9 : 4'd4;
                S_PLO: if (timer_done && pulse_cnt > 4'd1) pulse_cnt <= pulse_cnt - 4'd1;
                S_GAP: begin
                    if (timer_done) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt != 3'd7) begin
                            pulse_cnt <= shreg[6] ? 4'd9 : 4'd4;
                        end else if (name_phase) begin
                            name_phase <= 1'b0;
                            rd_addr    <= 14'd0;
                        end else if (!last_byte) begin
                            rd_addr <= rd_addr + 14'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tape_out = (state == S_PHI) ^ (POLARITY != 0);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_zx81_tape_player.sv
// Directed bench for zx81_tape_player: three instances cover timing, name byte and polarity.
module tb_zx81_tape_player;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic start0 = 0, stop0 = 0, out0, busy0, done0;
    logic start1 = 0, stop1 = 0, out1, busy1, done1;
    logic start2 = 0, stop2 = 0, out2, busy2, done2;
    logic [13:0] size0 = 0, size1 = 0, size2 = 0;
    logic [13:0] addr0, addr1, addr2, prog0, prog1, prog2;
    logic [7:0]  data0 = 0, data1 = 0, data2 = 0;
    logic [7:0]  ram0 [0:3];
    logic [7:0]  ram1 [0:3];
    logic [7:0]  ram2 [0:3];

    zx81_tape_player #(.CLK_HZ(1000000), .LEADER_US(100), .NAME_EN(0)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .start(start0), .stop(stop0), .tape_size(size0),
        .rd_addr(addr0), .rd_data(data0), .tape_out(out0), .busy(busy0), .done(done0),
        .progress(prog0));
    zx81_tape_player #(.CLK_HZ(1000000), .PULSE_US(2), .GAP_US(6), .LEADER_US(10),
                       .NAME_EN(1), .NAME_BYTE(8'hFF)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .start(start1), .stop(stop1), .tape_size(size1),
        .rd_addr(addr1), .rd_data(data1), .tape_out(out1), .busy(busy1), .done(done1),
        .progress(prog1));
    zx81_tape_player #(.CLK_HZ(1000000), .PULSE_US(2), .GAP_US(6), .LEADER_US(10),
                       .NAME_EN(0), .POLARITY(1)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .start(start2), .stop(stop2), .tape_size(size2),
        .rd_addr(addr2), .rd_data(data2), .tape_out(out2), .busy(busy2), .done(done2),
        .progress(prog2));

    // Tape RAM model: data valid one clock after the address.
    always @(posedge clk_sys) begin
        data0 <= ram0[addr0[1:0]];
        data1 <= ram1[addr1[1:0]];
        data2 <= ram2[addr2[1:0]];
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int dcnt0 = 0, dcyc0 = 0, rise0 = 0, bcnt0 = 0;
    int dcnt1 = 0, dcyc1 = 0, rise1 = 0, dcnt2 = 0;
    logic prev0 = 0, prev1 = 0;
    always @(negedge clk_sys) begin
        if (done0) begin dcnt0++; dcyc0 = cyc; end
        if (done1) begin dcnt1++; dcyc1 = cyc; end
        if (done2) dcnt2++;
        if (busy0) bcnt0++;
        if (out0 && !prev0) rise0++;
        if (out1 && !prev1) rise1++;
        prev0 = out0;
        prev1 = out1;
    end

    int errors = 0, checks = 0;
    int off = 0, s = 0;

    task automatic adv(input int n);
        repeat (n) begin @(posedge clk_sys); #1; end
        off += n;
    endtask

    task automatic go_to(input int k);
        adv(k - off);
    endtask

    task automatic kick(input int d);
        @(negedge clk_sys);
        case (d)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk_sys); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        off = 0;
        s = cyc;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL rst_out0: got %b want 0", out0); end
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", busy0, done0); end
        checks++; if (addr0 !== 14'd0 || prog0 !== 14'd0) begin errors++; $display("FAIL rst_addr_prog: got %0d/%0d want 0/0", addr0, prog0); end
        checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL rst_out_pol: got %b want 1", out2); end
        reset = 1'b0;
    endtask

    task automatic test_single_byte;
        int d0, r0;
        ram0[0] = 8'h80; size0 = 14'd1;
        d0 = dcnt0; r0 = rise0;
        kick(0);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL sb_busy: got %b want 1", busy0); end
        go_to(50);
        checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL sb_leader: got %b want 0", out0); end
        go_to(103);
        checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL sb_first_hi: got %b want 1", out0); end
        go_to(252);
        checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL sb_hi_end: got %b want 1", out0); end
        go_to(253);
        checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL sb_lo_start: got %b want 0", out0); end
        go_to(403);
        checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL sb_second_hi: got %b want 1", out0); end
        go_to(2900);
        checks++; if (out0 !== 1'b0 || rise0 - r0 != 9) begin errors++; $display("FAIL sb_gap1: got %b pulses %0d want 0 pulses 9", out0, rise0 - r0); end
        go_to(4103);
        checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL sb_bit1_hi: got %b want 1", out0); end
        go_to(21604);
        checks++; if (dcnt0 - d0 != 1 || dcyc0 != s + 21603) begin errors++; $display("FAIL sb_done: got cnt %0d at %0d want 1 at %0d", dcnt0 - d0, dcyc0 - s, 21603); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL sb_busy_end: got %b want 0", busy0); end
        checks++; if (rise0 - r0 != 37) begin errors++; $display("FAIL sb_pulses: got %0d want 37", rise0 - r0); end
    endtask

    task automatic test_back_to_back;
        int d0, r0;
        ram0[0] = 8'h80; size0 = 14'd1;
        d0 = dcnt0; r0 = rise0;
        kick(0);
        go_to(1000);
        start0 = 1'b1; adv(1); start0 = 1'b0;
        go_to(1003);
        checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL b2b_pulse4: got %b want 1", out0); end
        go_to(2900);
        checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", out0); end
        go_to(4103);
        checks++; if (out0 !== 1'b1 || addr0 !== 14'd0) begin errors++; $display("FAIL b2b_bit1: got %b addr %0d want 1 addr 0", out0, addr0); end
        go_to(21604);
        checks++; if (dcnt0 - d0 != 1 || dcyc0 != s + 21603) begin errors++; $display("FAIL b2b_done: got cnt %0d at %0d want 1 at %0d", dcnt0 - d0, dcyc0 - s, 21603); end
        checks++; if (rise0 - r0 != 37) begin errors++; $display("FAIL b2b_pulses: got %0d want 37", rise0 - r0); end
    endtask

    task automatic test_empty;
        int d0, r0, b0;
        size0 = 14'd0;
        d0 = dcnt0; r0 = rise0; b0 = bcnt0;
        kick(0);
        adv(10000);
        checks++; if (bcnt0 - b0 != 0) begin errors++; $display("FAIL empty_busy: got %0d busy clks want 0", bcnt0 - b0); end
        checks++; if (dcnt0 - d0 != 0 || rise0 - r0 != 0) begin errors++; $display("FAIL empty_quiet: got done %0d pulses %0d want 0 0", dcnt0 - d0, rise0 - r0); end
    endtask

    task automatic test_abort;
        int d0;
        ram0[0] = 8'h80; ram0[1] = 8'h00; size0 = 14'd2;
        d0 = dcnt0;
        kick(0);
        go_to(709);
        checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL abort_phi3: got %b want 1", out0); end
        stop0 = 1'b1; adv(1); stop0 = 1'b0;
        checks++; if (out0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL abort_now: got out %b busy %b want 0 0", out0, busy0); end
        adv(300);
        checks++; if (dcnt0 - d0 != 0) begin errors++; $display("FAIL abort_nodone: got %0d want 0", dcnt0 - d0); end
        kick(0);
        checks++; if (busy0 !== 1'b1 || addr0 !== 14'd0) begin errors++; $display("FAIL replay_start: got busy %b addr %0d want 1 0", busy0, addr0); end
        go_to(103);
        checks++; if (out0 !== 1'b1 || prog0 !== 14'd0) begin errors++; $display("FAIL replay_hi: got %b prog %0d want 1 0", out0, prog0); end
        stop0 = 1'b1; adv(1); stop0 = 1'b0;
        @(negedge clk_sys); start0 = 1'b1; stop0 = 1'b1;
        @(posedge clk_sys); #1; start0 = 1'b0; stop0 = 1'b0;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL start_stop_same: got busy %b want 0", busy0); end
    endtask

    task automatic test_name;
        int d1, r1;
        ram1[0] = 8'h00; ram1[1] = 8'h01; size1 = 14'd2;
        d1 = dcnt1; r1 = rise1;
        kick(1);
        go_to(11);
        checks++; if (out1 !== 1'b0) begin errors++; $display("FAIL name_bitstart: got %b want 0", out1); end
        go_to(12);
        checks++; if (out1 !== 1'b1) begin errors++; $display("FAIL name_first_hi: got %b want 1", out1); end
        go_to(340);
        checks++; if (rise1 - r1 != 72 || addr1 !== 14'd0) begin errors++; $display("FAIL name_pulses: got %0d addr %0d want 72 addr 0", rise1 - r1, addr1); end
        go_to(400);
        checks++; if (prog1 !== 14'd0 || addr1 !== 14'd0) begin errors++; $display("FAIL name_byte0: got prog %0d addr %0d want 0 0", prog1, addr1); end
        go_to(527);
        checks++; if (addr1 !== 14'd1 || prog1 !== 14'd0) begin errors++; $display("FAIL name_addr1: got addr %0d prog %0d want 1 0", addr1, prog1); end
        go_to(530);
        checks++; if (prog1 !== 14'd1 || out1 !== 1'b1) begin errors++; $display("FAIL name_byte1: got prog %0d out %b want 1 1", prog1, out1); end
        go_to(727);
        checks++; if (dcnt1 - d1 != 1 || dcyc1 != s + 726) begin errors++; $display("FAIL name_done: got cnt %0d at %0d want 1 at 726", dcnt1 - d1, dcyc1 - s); end
        checks++; if (rise1 - r1 != 141 || busy1 !== 1'b0) begin errors++; $display("FAIL name_total: got %0d busy %b want 141 0", rise1 - r1, busy1); end
    endtask

    task automatic test_shrink;
        int d1;
        size1 = 14'd2;
        d1 = dcnt1;
        kick(1);
        go_to(400);
        size1 = 14'd1;
        go_to(528);
        checks++; if (dcnt1 - d1 != 1 || dcyc1 != s + 527) begin errors++; $display("FAIL shrink_done: got cnt %0d at %0d want 1 at 527", dcnt1 - d1, dcyc1 - s); end
        checks++; if (addr1 !== 14'd0 || busy1 !== 1'b0) begin errors++; $display("FAIL shrink_addr: got addr %0d busy %b want 0 0", addr1, busy1); end
        size1 = 14'd2;
    endtask

    task automatic test_polarity;
        int d2;
        ram2[0] = 8'h00; size2 = 14'd1;
        d2 = dcnt2;
        kick(2);
        go_to(5);
        checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL pol_leader: got %b want 1", out2); end
        go_to(13);
        checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL pol_pulse_lo: got %b want 0", out2); end
        go_to(15);
        checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL pol_pulse_idle: got %b want 1", out2); end
        go_to(30);
        checks++; if (out2 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL pol_gap: got out %b busy %b want 1 1", out2, busy2); end
        reset = 1'b1; adv(1); reset = 1'b0;
        checks++; if (out2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL pol_reset: got out %b busy %b done %b want 1 0 0", out2, busy2, done2); end
        checks++; if (addr2 !== 14'd0 || prog2 !== 14'd0) begin errors++; $display("FAIL pol_reset_addr: got %0d/%0d want 0/0", addr2, prog2); end
        adv(50);
        checks++; if (dcnt2 - d2 != 0 || out2 !== 1'b1) begin errors++; $display("FAIL pol_after: got done %0d out %b want 0 1", dcnt2 - d2, out2); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ram0[i] = 8'h00; ram1[i] = 8'h00; ram2[i] = 8'h00;
        end
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_empty;
        test_abort;
        test_name;
        test_shrink;
        test_polarity;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
